axi_master_engine: RTL
======================

AXI_MASTER_ENGINE -- requirements
Module: axi_master_engine

Interface
REQ-001 Parameter ID_W, default 4, AXI ID width.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-004 Parameter TMO_CYC, default 1024, number of stalled handshake cycles before timeout.
REQ-005 The block SHALL use one clock, with reset synchronous and active-low.
REQ-006 clk  in  1  clock; all logic on posedge.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-009 cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst  in  1/ID_W/ADDR_W/4/3/2  command fields (write=1, read=0).
REQ-010 wd_valid/wd_ready, wd_data, wd_strb  in/out, in, in  1/1, DATA_W, DATA_W/8  write-beat source.
REQ-011 rd_valid/rd_ready, rd_data, rd_last  out/in, out, out  1/1, DATA_W, 1  read-beat sink.
REQ-012 done_valid, done_id, done_resp  out  1/ID_W/2  one-cycle completion pulse; done_resp carries the transaction status.
REQ-013 AW channel: awvalid out, awready in, plus awid/awlen/awsize/awaddr/awburst out.
REQ-014 W channel: wvalid out, wready in, plus wid/wdata/wstrb/wlast out.
REQ-015 B channel: bvalid/bid/bresp in, bready out.
REQ-016 AR channel: arvalid out, arready in, plus arid/araddr/arlen/arsize/arburst out.
REQ-017 R channel: rvalid/rid/rdata/rstrb/rresp/rlast in, rready out.

Function
REQ-018 FSM states: IDLE, AW, W, B, AR, R, DONE; exactly one transaction outstanding at a time.
REQ-019 IDLE: cmd_ready=1; on cmd_valid the command is latched and the FSM moves to AW (write) or AR (read).
REQ-020 AW/AR: valid is held high with stable fields until ready; on ready the FSM moves to W or R.
REQ-021 W: wvalid=wd_valid and wd_ready=wready (combinational pass-through).
REQ-022 W: wid is the latched ID; wlast=1 when beat_cnt==latched len; on the last handshake the FSM moves to B.
REQ-023 beat_cnt is 5 bits, cleared on command accept, incremented per beat, so len=15 gives 16 beats without wrap.
REQ-024 B: bready=1; on bvalid the FSM moves to DONE.
REQ-025 B: status is bresp, or 2'b10 if bid differs from the latched ID.
REQ-026 R: rready=rd_ready and rd_valid=rvalid, with rd_data=rdata and rd_last=rlast.
REQ-027 R: a beat with rresp!=0 sets the status to the worst value (max) seen.
REQ-028 R: rlast arriving at beat_cnt!=len, or beat len arriving without rlast, sets status 2'b10; the FSM leaves R on rlast only.
REQ-029 DONE: done_valid=1 for exactly one cycle, then the FSM returns to IDLE; a new command is accepted no earlier than the following cycle.
REQ-030 Timeout: a counter increments in each non-IDLE cycle with no handshake on the active channel and clears on any handshake.
REQ-031 On reaching TMO_CYC the engine drops all valids/readies, reports done_resp=2'b11 and enters DONE.
REQ-032 Simultaneous valid and ready on the same edge SHALL complete the handshake in that cycle.

Reset
REQ-033 While rstn=0 at posedge: state=IDLE; all AXI valid/ready outputs=0; cmd_ready=0; done_valid=0; counters=0; latched fields=0.
REQ-034 Reset mid-transaction SHALL abandon it with no done pulse; cmd_ready=1 from the first cycle after release.

Structure
REQ-035 Shared package axi_if_pkg SHALL hold the state enum, the response constants (OKAY, EXOKAY, SLVERR, DECERR) and the burst encodings (FIXED, INCR, WRAP).
REQ-036 The timeout watchdog SHALL be one sub-module, axi_hs_watchdog.

Verification
REQ-037 Write: addr 0x100, len 3, INCR, id 5, memory always ready -> 4 W beats, wlast on the 4th, done_id=5, done_resp=0.
REQ-038 Read: len 15, with rd_ready toggling every other cycle -> 16 beats delivered in order, rd_last on the 16th, done_resp=0.
REQ-039 Read: rlast asserted on beat 2 of len 3 -> done_resp=2'b10; the FSM returns to IDLE.
REQ-040 Write: bid=3 returned for latched id 5 -> done_resp=2'b10.
REQ-041 Read: arready held low for TMO_CYC cycles -> arvalid drops, done_resp=2'b11.
REQ-042 Reset asserted during the W state at beat 2 -> all valids 0 the next cycle, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_if_pkg.sv
// Purpose: shared types and constants for the AXI master engine and its watchdog.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package axi_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Responses are ordered by severity, so the worst one is the numeric max.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_hs_watchdog.sv
// Purpose: counts consecutive stalled cycles on the active channel and flags expiry.
// Latency: expire_o is combinational, asserted during the TMO_CYC-th consecutive stalled cycle.
// Backpressure: none; observes handshakes only.
// Ports: clk, rstn (sync active-low); active_i = a channel is in use this cycle;
//        hs_i = a handshake completes this cycle; expire_o = timeout reached.
module axi_hs_watchdog #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic active_i,
    input  logic hs_i,
    output logic expire_o
);

    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of stalled cycles already elapsed, so the
    // current stalled cycle is the last allowed one when cnt_q == TMO_CYC-1.
    assign expire_o = active_i && !hs_i && (cnt_q == CNT_W'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || hs_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_master_engine.sv
// Purpose: single-outstanding AXI master; turns one command into AW/W/B or AR/R and reports status.
// Latency: command taken in IDLE, one cycle per handshake, done pulse the cycle after B or the last R beat.
// Backpressure: valids held until ready; W/R beats pass straight through so source/sink stalls stall AXI.
// Ports: clk/rstn (sync active-low); cmd_* command; wd_* write-beat source; rd_* read-beat sink;
//        done_* one-cycle completion; aw*/w*/b*/ar*/r* AXI master channels.
module axi_master_engine
    import axi_if_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id,
    output logic [1:0]        done_resp,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   awid,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [ADDR_W-1:0] awaddr,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic              wlast,
    input  logic              bvalid,
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    output logic              bready,
    output logic              arvalid,
    input  logic              arready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W/8-1:0] rstrb,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              rready
);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [4:0]          beat_q, beat_d;
    logic [1:0]          status_q, status_d;

    logic                hs;
    logic                chan_active;
    logic                tmo_expire;
    logic                last_beat;
    logic [1:0]          r_status;

    // Read ID and read strobes carry nothing this engine acts on.
    logic                unused_rx;
    assign unused_rx = ^{rid, rstrb};

    // beat_cnt is one bit wider than len so a 16-beat burst never wraps to 0.
    assign last_beat = (beat_q == {1'b0, len_q});

    assign chan_active = (state_q != ST_IDLE) && (state_q != ST_DONE);

    axi_hs_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rstn     (rstn),
        .active_i (chan_active),
        .hs_i     (hs),
        .expire_o (tmo_expire)
    );

    // Address channels reflect the latched command for its whole lifetime.
    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awburst = burst_q;
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = burst_q;
    assign wid     = id_q;
    assign wdata   = wd_data;
    assign wstrb   = wd_strb;
    assign rd_data = rdata;
    assign rd_last = rlast;
    assign done_id   = id_q;
    assign done_resp = status_q;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        status_d   = status_q;
        r_status   = status_q;
        hs         = 1'b0;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wd_ready   = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        done_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = rstn;
                if (cmd_valid) begin
                    write_d  = cmd_write;
                    id_d     = cmd_id;
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    size_d   = cmd_size;
                    burst_d  = cmd_burst;
                    beat_d   = '0;
                    status_d = RESP_OKAY;
                    state_d  = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                awvalid = 1'b1;
                hs      = awready;
                if (awready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                wvalid   = wd_valid;
                wd_ready = wready;
                wlast    = last_beat;
                hs       = wd_valid && wready;
                if (hs) begin
                    beat_d = beat_q + 5'd1;
                    if (last_beat) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                bready = 1'b1;
                hs     = bvalid;
                if (bvalid) begin
                    status_d = (bid != id_q) ? RESP_SLVERR : bresp;
                    state_d  = ST_DONE;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                hs      = arready;
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                hs       = rvalid && rd_ready;
                if (hs) begin
                    beat_d = beat_q + 5'd1;
                    if (rresp != RESP_OKAY) begin
                        r_status = resp_worst(r_status, rresp);
                    end
                    // rlast must coincide exactly with the beat numbered len.
                    if (rlast != last_beat) begin
                        r_status = resp_worst(r_status, RESP_SLVERR);
                    end
                    status_d = r_status;
                    if (rlast) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Expiry only fires on a stalled cycle, so no beat is counted here;
        // DONE drives every valid/ready low from the next cycle on.
        if (tmo_expire) begin
            status_d = RESP_DECERR;
            state_d  = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            status_q <= status_d;
        end
    end

endmodule
